// File: rtl/guess_entry.sv
// Collects one Bulls & Cows code, one distinct BCD digit per confirm pulse,
// and offers it to the game FSM through a valid/ack handshake.
module guess_entry #(
  parameter int NDIG = 4,
  parameter int DW   = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 confirma,
  input  logic                 clear,
  input  logic [DW-1:0]        sw,
  input  logic                 ack,
  output logic [NDIG*DW-1:0]   code_out,
  output logic                 code_valid,
  output logic [2:0]           digit_count,
  output logic                 erro
);

  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

  state_t              state_q, state_d;
  logic [NDIG*DW-1:0]  code_q, code_d;
  logic                valid_q, valid_d;
  logic [2:0]          cnt_q, cnt_d;
  logic                erro_q, erro_d;
  logic [9:0]          mask_q, mask_d;
  logic [(1<<DW)-1:0]  used_ext;
  logic                digit_ok;

  // Widen the mask to the full switch range so out-of-range codes index safely.
  always_comb begin
    used_ext       = '0;
    used_ext[9:0]  = mask_q;
    digit_ok       = (sw <= DW'(9)) && !used_ext[sw];
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    erro_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = COLLECT;
          code_d  = '0;
          cnt_d   = '0;
          mask_d  = '0;
        end
      end
      COLLECT: begin
        if (!enable || clear) begin
          state_d = enable ? COLLECT : IDLE;
          code_d  = '0;
          cnt_d   = '0;
          mask_d  = '0;
        end else if (confirma) begin
          if (digit_ok) begin
            code_d = {code_q[NDIG*DW-DW-1:0], sw};
            mask_d = mask_q | (10'(1) << sw);
            cnt_d  = cnt_q + 3'd1;
            if (cnt_q == 3'(NDIG-1)) begin
              state_d = HOLD;
              valid_d = 1'b1;
            end
          end else begin
            erro_d = 1'b1;
          end
        end
      end
      HOLD: begin
        // ack and clear both restart entry; ack only differs in that the
        // consumer has already latched code_out this cycle.
        if (!enable) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end else if (ack || clear) begin
          state_d = COLLECT;
          valid_d = 1'b0;
          code_d  = '0;
          cnt_d   = '0;
          mask_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      code_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      erro_q  <= 1'b0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      erro_q  <= erro_d;
      mask_q  <= mask_d;
    end
  end

  assign code_out    = code_q;
  assign code_valid  = valid_q;
  assign digit_count = cnt_q;
  assign erro        = erro_q;

endmodule

// File: doc/guess_entry.md
# guess_entry

Collects one four-digit Bulls & Cows guess (or secret) from the board switches, one digit per debounced confirm pulse. It sits directly downstream of the push-button edge detector, whose single-cycle `rising_confirma` pulse drives `confirma` here, and upstream of the game FSM, which receives a validated 16-bit BCD code through a valid/ack handshake. Digits must be 0–9 and pairwise distinct; offending entries are rejected with a one-cycle `erro` pulse.

## Interface
- `NDIG`, default 4: digits per code (spec and tests fixed at 4).
- `DW`, default 4: bits per digit (BCD).
- `clock`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  level from the game FSM; high while it accepts entry.
- `confirma`  in  1  single-cycle confirm pulse from the edge detector.
- `clear`  in  1  single-cycle pulse; discards the partial entry.
- `sw`  in  DW  current digit value from the switches.
- `ack`  in  1  game FSM has consumed `code_out`.
- `code_out`  out  NDIG*DW  entered digits; the first digit entered ends in [15:12] after four accepts.
- `code_valid`  out  1  high while a complete code is held.
- `digit_count`  out  3  number of digits accepted so far (0–4).
- `erro`  out  1  one-cycle pulse on a rejected digit.

## Operation
- State register with three states: IDLE, COLLECT, HOLD.
- Internal `mask[9:0]` marks digits already used in the current entry.
- Reset values: state IDLE, `code_out`=0, `code_valid`=0, `digit_count`=0, `erro`=0, `mask`=0.
- Every entry into COLLECT clears `code_out`, `digit_count` and `mask`.
- IDLE:
  - `confirma`, `clear` and `ack` are ignored.
  - `enable`=1 → COLLECT.
- COLLECT, with input priority `enable`=0 > `clear` > `confirma`:
  - `enable`=0 → IDLE. `code_out`, `digit_count` and `mask` are cleared.
  - `clear` → stay in COLLECT, cleared. A simultaneous `confirma` is dropped and `erro` is not raised.
  - `confirma` with `sw`>9 or `mask[sw]`=1 → `erro`=1 for one cycle; no other change.
  - `confirma` with a valid, unused digit → `code_out` <= {`code_out`[11:0], `sw`}, `mask[sw]` <= 1, `digit_count`+1.
  - When the accepted digit is the 4th one → HOLD with `code_valid`=1 on the same edge.
- HOLD:
  - `code_out` is frozen and `digit_count`=4.
  - `confirma` is ignored; no `erro` is raised.
  - Priority is `enable`=0 > `ack` > `clear`.
  - `enable`=0 → IDLE, `code_valid`=0.
  - `ack` → `code_valid`=0, then COLLECT (which clears `code_out`).
  - `clear` → COLLECT, `code_valid`=0, without handing over the code.
- Digit 0 is a legal digit, including as the first digit.
- `erro` is never high for two consecutive cycles unless two consecutive `confirma` pulses are both rejected.
- A reset asserted in any state returns immediately, asynchronously, to the reset values. No partial code survives.

## Timing
- `confirma` high at edge k → `code_out`, `digit_count`, `mask` and `erro` are updated at edge k. They are visible from cycle k+1 (one-cycle latency).
- 4th valid `confirma` at edge k → `code_valid`=1 from cycle k+1.
- `code_valid` stays high until the edge at which `ack`=1 is sampled. The game FSM must capture `code_out` while `code_valid`&&`ack` are both high.
- `code_out` clears on the `ack` edge.
- `enable` rising at edge k (state IDLE) → COLLECT from cycle k+1. A `confirma` at edge k is ignored.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- Reset mid-entry: after two digits, assert `reset` → all outputs 0 and state IDLE immediately. A subsequent `confirma` with `enable`=0 → no change.
- Normal entry: `enable`=1, then `confirma` with `sw`=1, 2, 3, 4 → `digit_count` goes 1→4. Then `code_out`=16'h1234 and `code_valid`=1. `ack` → `code_valid`=0 and `code_out`=0.
- Duplicate and invalid digits: enter 5, 5, 12, 0, 7, 9 → `erro` pulses on the 2nd and 3rd entries only. Result `code_out`=16'h5079.
- Clear: enter 8, 6, pulse `clear` → `digit_count`=0 and `mask` empty. Entering 8, 6, 1, 2 is accepted → 16'h8612.
- Simultaneous events:
  - `clear` and a valid `confirma` at the same edge in COLLECT → entry cleared, digit not stored, no `erro`.
  - `ack` and `clear` at the same edge in HOLD → `ack` wins, code handed over.
- HOLD robustness: with `code_valid`=1, pulse `confirma` with `sw`=3 → `code_out` unchanged and no `erro`. Dropping `enable` → IDLE, `code_valid`=0.
